// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer followed by a counter-qualified FSM.
// The output level Q follows the synchronized input only after it has held a
// new value for STABLE_CYCLES consecutive cycles; abandoned candidates raise
// a one-cycle glitch pulse.
module debounce_sync #(
    parameter int   STABLE_CYCLES = 4,
    parameter int   CNT_W         = 8,
    parameter logic INIT          = 1'b0
) (
    input  logic clk,
    input  logic R,
    input  logic A,
    output logic Q,
    output logic busy,
    output logic glitch
);

    // Counter value at which the next differing sample accepts the candidate.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    // STABLE: no candidate pending (cnt == 0); CHECK: qualifying (cnt != 0).
    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic             s1_q;
    logic             s2_q;
    logic             q_q;
    logic             q_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             glitch_q;
    logic             glitch_d;
    state_t           state;

    // Synchronizer chain; A is only ever seen through s2.
    always_ff @(posedge clk) begin
        if (R) begin
            s1_q <= INIT;
            s2_q <= INIT;
        end else begin
            s1_q <= A;
            s2_q <= s1_q;
        end
    end

    // FSM state registers: debounced level, qualification count, glitch flag.
    always_ff @(posedge clk) begin
        if (R) begin
            q_q      <= INIT;
            cnt_q    <= '0;
            glitch_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    // Next-state logic: accept, keep qualifying, reject bounce, or hold.
    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        glitch_d = 1'b0;
        state    = (cnt_q != '0) ? ST_CHECK : ST_STABLE;

        if (s2_q != q_q) begin
            if (cnt_q == LAST_CNT) begin
                // Candidate held long enough: take it and return to STABLE.
                q_d   = s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state == ST_CHECK) begin
            // Input fell back to the current level before qualifying.
            cnt_d    = '0;
            glitch_d = 1'b1;
        end
    end

    // Outputs are decoded from registers only, so A never reaches them combinationally.
    assign Q      = q_q;
    assign busy   = (cnt_q != '0);
    assign glitch = glitch_q;

endmodule
